// File: rtl/move_scheduler.sv
// Grid move scheduler: arbitrates button and autonomous move requests, applies one per frame tick.
// Optional MOVE_SCHED_WRAP_EN wraps moves at the grid edges instead of clamping them.
//
// state | meaning
// IDLE  | waiting for a button pulse or an autonomous request
// PEND  | one move latched, waiting for the next frame_tick to apply it
module move_scheduler #(
  parameter int GRID_MAX = 19,
  parameter int START_X  = 9,
  parameter int START_Y  = 9
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [3:0] btn_req,
  input  logic       frame_tick,
  input  logic       auto_valid,
  input  logic [1:0] auto_dir,
  output logic       auto_ready,
  output logic [7:0] xpos,
  output logic [7:0] ypos,
  output logic       move_done,
  output logic       blocked,
  output logic [7:0] drop_count
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [7:0] GMAX = 8'(GRID_MAX);
  localparam logic [7:0] X0   = 8'(START_X);
  localparam logic [7:0] Y0   = 8'(START_Y);

  state_t     state;
  logic [1:0] dir;
  logic [2:0] btn_cnt;
  logic [1:0] btn_low;
  logic [2:0] drop_inc;
  logic [8:0] drop_sum;
  logic [7:0] drop_next;
  logic [7:0] nx, ny;
  logic       blk_next;

  assign auto_ready = (state == IDLE) && (btn_req == 4'b0000);

  always_comb begin
    btn_cnt = 3'(btn_req[0]) + 3'(btn_req[1]) + 3'(btn_req[2]) + 3'(btn_req[3]);
    btn_low = 2'd0;
    if (btn_req[0])      btn_low = 2'd0;
    else if (btn_req[1]) btn_low = 2'd1;
    else if (btn_req[2]) btn_low = 2'd2;
    else if (btn_req[3]) btn_low = 2'd3;
    // In IDLE the lowest set bit becomes the move; only the rest count as drops.
    drop_inc = 3'd0;
    if (state == PEND)           drop_inc = btn_cnt;
    else if (btn_req != 4'b0000) drop_inc = btn_cnt - 3'd1;
    drop_sum  = {1'b0, drop_count} + 9'(drop_inc);
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    nx       = xpos;
    ny       = ypos;
    blk_next = 1'b0;
    case (dir)
      2'd0: if (ypos == 8'd0) begin
`ifdef MOVE_SCHED_WRAP_EN
              ny = GMAX;
`else
              blk_next = 1'b1;
`endif
            end else ny = ypos - 8'd1;
      2'd1: if (xpos == 8'd0) begin
`ifdef MOVE_SCHED_WRAP_EN
              nx = GMAX;
`else
              blk_next = 1'b1;
`endif
            end else nx = xpos - 8'd1;
      2'd2: if (xpos >= GMAX) begin
`ifdef MOVE_SCHED_WRAP_EN
              nx = 8'd0;
`else
              blk_next = 1'b1;
`endif
            end else nx = xpos + 8'd1;
      default: if (ypos >= GMAX) begin
`ifdef MOVE_SCHED_WRAP_EN
              ny = 8'd0;
`else
              blk_next = 1'b1;
`endif
            end else ny = ypos + 8'd1;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= 2'd0;
      xpos       <= X0;
      ypos       <= Y0;
      move_done  <= 1'b0;
      blocked    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      move_done  <= 1'b0;
      blocked    <= 1'b0;
      drop_count <= drop_next;
      case (state)
        IDLE: begin
          // frame_tick is deliberately ignored here, even on the latch edge.
          if (btn_req != 4'b0000) begin
            dir   <= btn_low;
            state <= PEND;
          end else if (auto_valid) begin
            dir   <= auto_dir;
            state <= PEND;
          end
        end
        PEND: begin
          if (frame_tick) begin
            xpos      <= nx;
            ypos      <= ny;
            move_done <= 1'b1;
            blocked   <= blk_next;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: vector table of moves plus hand sequences for
// priority, latch-edge tick, grid edges, drop saturation and reset during a pending move.
module tb_move_scheduler;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [3:0] btn_req;
  logic       frame_tick;
  logic       auto_valid;
  logic [1:0] auto_dir;
  logic       auto_ready;
  logic [7:0] xpos, ypos, drop_count;
  logic       move_done, blocked;

  move_scheduler dut (
    .clk_in(clk_in), .reset(reset), .btn_req(btn_req), .frame_tick(frame_tick),
    .auto_valid(auto_valid), .auto_dir(auto_dir), .auto_ready(auto_ready),
    .xpos(xpos), .ypos(ypos), .move_done(move_done), .blocked(blocked),
    .drop_count(drop_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       blk;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    logic       av;
    logic [1:0] adir;
    int         extra;
    logic [7:0] ex;
    logic [7:0] ey;
    logic       eblk;
    logic [7:0] edrop;
  } vec_t;

  exp_t q[$];
  vec_t vecs[8];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard: every move_done pops the oldest expected move.
  always @(posedge clk_in) begin
    #1;
    if (move_done) begin
      if (q.size() == 0) check("spurious_move_done", move_done, 1'b0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("move_x", xpos, e.x);
        check("move_y", ypos, e.y);
        check("move_blocked", blocked, e.blk);
      end
    end else begin
      check("blocked_without_done", blocked, 1'b0);
    end
  end

  task automatic do_move(input logic [3:0] b, input logic av, input logic [1:0] ad,
                         input int extra, input logic [7:0] ex, input logic [7:0] ey,
                         input logic eb, input logic [7:0] ed);
    btn_req = b; auto_valid = av; auto_dir = ad;
    #1 check("ready_idle", auto_ready, (b == 4'b0000));
    q.push_back(exp_t'{ex, ey, eb});
    step();
    btn_req = 4'b0000; auto_valid = 1'b0;
    #1 check("ready_pend", auto_ready, 1'b0);
    repeat (extra) begin
      btn_req = 4'b0100; step();
      btn_req = 4'b0000; step();
    end
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
    check("drop_count", drop_count, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0100, 1'b0, 2'd0, 0, 8'd10, 8'd9, 1'b0, 8'd0};
    vecs[1] = '{4'b1010, 1'b0, 2'd0, 0, 8'd9,  8'd9, 1'b0, 8'd1};
    vecs[2] = '{4'b0000, 1'b1, 2'd0, 0, 8'd9,  8'd8, 1'b0, 8'd1};
    vecs[3] = '{4'b0000, 1'b1, 2'd3, 0, 8'd9,  8'd9, 1'b0, 8'd1};
    vecs[4] = '{4'b0001, 1'b0, 2'd0, 3, 8'd9,  8'd8, 1'b0, 8'd4};
    vecs[5] = '{4'b1111, 1'b0, 2'd0, 0, 8'd9,  8'd7, 1'b0, 8'd7};
    vecs[6] = '{4'b1000, 1'b0, 2'd0, 0, 8'd9,  8'd8, 1'b0, 8'd7};
    vecs[7] = '{4'b0000, 1'b1, 2'd2, 0, 8'd10, 8'd8, 1'b0, 8'd7};

    reset = 1'b1; btn_req = 4'b0000; frame_tick = 1'b0; auto_valid = 1'b0; auto_dir = 2'd0;
    #2;
    check("rst_x", xpos, 8'd9);
    check("rst_y", ypos, 8'd9);
    check("rst_drop", drop_count, 8'd0);
    check("rst_done", move_done, 1'b0);
    check("rst_ready", auto_ready, 1'b1);
    #10 reset = 1'b0;
    step();

    foreach (vecs[i])
      do_move(vecs[i].btn, vecs[i].av, vecs[i].adir, vecs[i].extra,
              vecs[i].ex, vecs[i].ey, vecs[i].eblk, vecs[i].edrop);

    // Button wins over a simultaneous auto request; auto is taken in the next IDLE cycle.
    btn_req = 4'b0001; auto_valid = 1'b1; auto_dir = 2'd1;
    #1 check("prio_ready", auto_ready, 1'b0);
    q.push_back(exp_t'{8'd10, 8'd7, 1'b0});
    step();
    btn_req = 4'b0000;
    check("prio_ready_pend", auto_ready, 1'b0);
    check("prio_drop", drop_count, 8'd7);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0;
    check("prio_auto_ready", auto_ready, 1'b1);
    q.push_back(exp_t'{8'd9, 8'd7, 1'b0});
    step();
    auto_valid = 1'b0;
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();

    // A tick on the latch edge must not apply the move.
    btn_req = 4'b0100; frame_tick = 1'b1;
    q.push_back(exp_t'{8'd10, 8'd7, 1'b0});
    step();
    btn_req = 4'b0000; frame_tick = 1'b0;
    check("latch_tick_x", xpos, 8'd9);
    check("latch_tick_ready", auto_ready, 1'b0);
    step();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();

    for (int k = 9; k >= 0; k--)
      do_move(4'b0010, 1'b0, 2'd0, 0, 8'(k), 8'd7, 1'b0, 8'd7);
`ifdef MOVE_SCHED_WRAP_EN
    do_move(4'b0010, 1'b0, 2'd0, 0, 8'd19, 8'd7, 1'b0, 8'd7);
    do_move(4'b0100, 1'b0, 2'd0, 0, 8'd0,  8'd7, 1'b0, 8'd7);
`else
    do_move(4'b0010, 1'b0, 2'd0, 0, 8'd0,  8'd7, 1'b1, 8'd7);
    do_move(4'b0100, 1'b0, 2'd0, 0, 8'd1,  8'd7, 1'b0, 8'd7);
`endif

    // 300 dropped bits while pending saturate the counter.
    btn_req = 4'b0010;
`ifdef MOVE_SCHED_WRAP_EN
    q.push_back(exp_t'{8'd19, 8'd7, 1'b0});
`else
    q.push_back(exp_t'{8'd0, 8'd7, 1'b0});
`endif
    step();
    btn_req = 4'b1111;
    repeat (75) step();
    btn_req = 4'b0000;
    check("sat_drop", drop_count, 8'd255);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
    check("sat_hold", drop_count, 8'd255);

    // Reset during PEND discards the move.
    btn_req = 4'b0100; step();
    btn_req = 4'b0000;
    #2 reset = 1'b1;
    #1;
    check("rstp_x", xpos, 8'd9);
    check("rstp_y", ypos, 8'd9);
    check("rstp_drop", drop_count, 8'd0);
    check("rstp_done", move_done, 1'b0);
    step();
    reset = 1'b0;
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step(); step();
    check("rstp_idle", auto_ready, 1'b1);
    check("rstp_x_hold", xpos, 8'd9);
    do_move(4'b0100, 1'b0, 2'd0, 0, 8'd10, 8'd9, 1'b0, 8'd0);

    step();
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter GRID_MAX, default 19: highest legal grid coordinate on each axis; legal range 0..GRID_MAX.
REQ-002 Parameter START_X, default 9: x coordinate after reset.
REQ-003 Parameter START_Y, default 9: y coordinate after reset.
REQ-004 Port clk_in  input  1: single system clock; all state on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port btn_req  input  4: debounced one-cycle move pulses; bit0 up (y-1), bit1 left (x-1), bit2 right (x+1), bit3 down (y+1).
REQ-007 Port frame_tick  input  1: one-cycle pulse per video frame, synchronous to clk_in.
REQ-008 Port auto_valid  input  1: autonomous mover request valid.
REQ-009 Port auto_dir  input  2: autonomous direction; 0 up, 1 left, 2 right, 3 down.
REQ-010 Port auto_ready  output  1: request accepted this cycle when auto_valid and auto_ready are both high.
REQ-011 Port xpos  output  8: current block x coordinate.
REQ-012 Port ypos  output  8: current block y coordinate.
REQ-013 Port move_done  output  1: one-cycle pulse, a pending move was applied.
REQ-014 Port blocked  output  1: one-cycle pulse, coincident with move_done, move suppressed at a grid edge.
REQ-015 Port drop_count  output  8: requests discarded while busy, saturating.

Function
REQ-016 States IDLE and PEND, registered; reset state IDLE.
REQ-017 IDLE with btn_req nonzero: latch lowest-numbered set bit as pending direction, source=button, go PEND next edge.
REQ-018 auto_ready shall be combinational: high exactly when state is IDLE and btn_req is zero.
REQ-019 IDLE with btn_req zero and auto_valid high: accept auto_dir (handshake completes), go PEND.
REQ-020 Button pulses take priority over auto_valid in the same cycle; auto request stays unaccepted and auto_valid holder must keep it stable.
REQ-021 frame_tick is ignored in IDLE, including the cycle a request is latched; minimum latency request-to-apply is the next frame_tick after entry to PEND.
REQ-022 PEND with frame_tick high: update xpos/ypos on that edge, return to IDLE, assert move_done for the following cycle.
REQ-023 PEND with frame_tick low: hold; auto_ready low.
REQ-024 Any btn_req pulse arriving in PEND (except on the apply edge it is also dropped) shall increment drop_count by the number of set bits, saturating at 255; pending move unchanged.
REQ-025 Multiple btn_req bits set in IDLE: one move latched (lowest bit), remaining set bits added to drop_count.
REQ-026 Edge handling without WRAP_EN: move below 0 or above GRID_MAX leaves coordinate unchanged and pulses blocked with move_done.
REQ-027 Coordinates are unsigned 8-bit; xpos, ypos never exceed GRID_MAX.
REQ-028 Exactly one coordinate changes per applied move, by exactly one (or wraps per REQ-032).

Reset
REQ-029 reset high asynchronously forces: state IDLE, xpos=START_X, ypos=START_Y, move_done=0, blocked=0, drop_count=0, pending move discarded.
REQ-030 Reset asserted during PEND discards the pending move; no move_done after release.
REQ-031 After reset deassertion, first edge with btn_req or auto_valid is handled per REQ-017/REQ-019.

Configuration
REQ-032 Macro MOVE_SCHED_WRAP_EN defined: edge moves wrap (0 minus 1 -> GRID_MAX, GRID_MAX plus 1 -> 0), blocked tied 0; undefined: clamp per REQ-026.

Verification
REQ-033 Reset, btn_req=4'b0100, one frame_tick later -> xpos 9->10, ypos 9, move_done one cycle, blocked 0.
REQ-034 btn_req=4'b0001 and auto_valid=1 same cycle -> auto_ready 0, up move latched, drop_count 0; after tick ypos=8, then auto request accepted in next IDLE cycle.
REQ-035 From xpos=0, left request, tick -> clamp build: xpos 0, blocked and move_done pulse; MOVE_SCHED_WRAP_EN build: xpos 19, blocked 0.
REQ-036 In PEND, three btn_req pulses before frame_tick -> drop_count=3, only original move applied; 300 drops -> drop_count=255.
REQ-037 Latch request, assert reset before frame_tick -> xpos=9, ypos=9, state IDLE, no move_done after release.
REQ-038 btn_req=4'b1010 in IDLE -> left move latched, drop_count=1; after tick xpos=8.
